// File: rtl/bits_test_pkg.sv
// Shared definitions for the bits_test generator / bits_check checker pair:
// pattern select codes, checker FSM states and the default pattern bytes.
package bits_test_pkg;

  typedef enum logic [1:0] {
    PAT_CONST = 2'b00,
    PAT_CNT   = 2'b01,
    PAT_HOT   = 2'b10,
    PAT_FF    = 2'b11
  } pat_e;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCK    = 2'd2
  } state_e;

  localparam logic [7:0] CONSTANT_DEF = 8'hbc;  // K28.5
  localparam logic [7:0] HOT_CODE_DEF = 8'haa;

endpackage

// File: rtl/bits_popcount.sv
// Combinational population count: per-byte counts feeding a balanced adder tree.
module bits_popcount #(
  parameter int W = 48
) (
  input  logic [W-1:0]             i_data,
  output logic [$clog2(W+1)-1:0]   o_count
);
  localparam int CW = $clog2(W+1);
  localparam int NB = (W + 7) / 8;
  localparam int NP = 1 << $clog2(NB);

  logic [NB*8-1:0]       pad;
  logic [NP-1:0][3:0]    byte_cnt;
  logic [CW-1:0]         acc [NP];

  assign pad = (NB*8)'(i_data);

  for (genvar b = 0; b < NP; b++) begin : g_byte
    if (b < NB) begin : g_cnt
      logic [3:0] c;
      always_comb begin
        c = '0;
        for (int i = 0; i < 8; i++) c = c + 4'(pad[b*8+i]);
      end
      assign byte_cnt[b] = c;
    end else begin : g_pad
      assign byte_cnt[b] = '0;
    end
  end

  // Leaves padded to a power of two so every level halves cleanly.
  always_comb begin
    for (int i = 0; i < NP; i++) acc[i] = CW'(byte_cnt[i]);
    for (int s = NP / 2; s > 0; s = s >> 1) begin
      for (int i = 0; i < s; i++) acc[i] = acc[2*i] + acc[2*i+1];
    end
    o_count = acc[0];
  end

endmodule

// File: rtl/bits_check.sv
// Receive-side pattern checker: locks onto the bits_test pattern, then flags
// mismatched words and keeps saturating word / bit error counts.
module bits_check
  import bits_test_pkg::*;
#(
  parameter int         DW         = 6,
  parameter logic [7:0] CONSTANT   = CONSTANT_DEF,
  parameter logic [7:0] HOT_CODE   = HOT_CODE_DEF,
  parameter int         LOCK_CNT   = 8,
  parameter int         UNLOCK_ERR = 4,
  parameter int         CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        i_test_patten,
  input  logic              i_data_vld,
  input  logic [DW*8-1:0]   i_test_data,
  input  logic              i_clr_cnt,
  output logic              o_locked,
  output logic              o_word_err,
  output logic [CNT_W-1:0]  o_word_err_cnt,
  output logic [CNT_W-1:0]  o_bit_err_cnt
);
  localparam int BW = DW * 8;
  localparam int PW = $clog2(BW + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_ERR + 1);
  localparam int SW = CNT_W + PW;

  localparam logic [BW-1:0]    W_CONST = {DW{CONSTANT}};
  localparam logic [BW-1:0]    W_HOT   = {DW{HOT_CODE}};
  localparam logic [BW-1:0]    W_HOTN  = {DW{~HOT_CODE}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [BW-1:0]     exp_q, exp_d;
  logic [GW-1:0]     good_q, good_d;
  logic [UW-1:0]     bad_q, bad_d;
  logic [1:0]        pat_q, pat_d;
  logic              word_err_q, word_err_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  logic [BW-1:0]     exp_cmp, exp_adv, seed_adv;
  logic [PW-1:0]     pop;
  logic [SW-1:0]     bit_sum;
  logic [GW-1:0]     good_inc;
  logic [UW-1:0]     bad_inc;
  logic              is_run, hot_legal, match, pat_chg, err_hit;

  // Fixed modes compare against a constant; running modes use the tracked word.
  always_comb begin
    unique case (i_test_patten)
      PAT_CONST: exp_cmp = W_CONST;
      PAT_FF:    exp_cmp = '1;
      default:   exp_cmp = exp_q;
    endcase
  end

  assign is_run    = (i_test_patten == PAT_CNT) || (i_test_patten == PAT_HOT);
  assign exp_adv   = (i_test_patten == PAT_CNT) ? exp_cmp + BW'(1) : ~exp_cmp;
  assign seed_adv  = (i_test_patten == PAT_CNT) ? i_test_data + BW'(1) : ~i_test_data;
  assign hot_legal = (i_test_data == W_HOT) || (i_test_data == W_HOTN);
  assign match     = (i_test_data == exp_cmp);
  assign pat_chg   = (i_test_patten != pat_q) && (state_q != HUNT);
  assign good_inc  = good_q + GW'(1);
  assign bad_inc   = bad_q + UW'(1);

  bits_popcount #(.W(BW)) u_pop (
    .i_data  (i_test_data ^ exp_cmp),
    .o_count (pop)
  );

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_hit = 1'b0;
    if (pat_chg) begin
      state_d = HUNT;
      good_d  = '0;
      bad_d   = '0;
    end else if (i_data_vld) begin
      unique case (state_q)
        HUNT: begin
          if (is_run) begin
            // Counter mode seeds from anything; hot mode only from a legal word.
            if ((i_test_patten == PAT_CNT) || hot_legal) begin
              exp_d   = seed_adv;
              good_d  = GW'(1);
              bad_d   = '0;
              state_d = (LOCK_CNT == 1) ? LOCK : CONFIRM;
            end
          end else if (match) begin
            good_d  = GW'(1);
            bad_d   = '0;
            state_d = (LOCK_CNT == 1) ? LOCK : CONFIRM;
          end
        end
        CONFIRM: begin
          if (is_run) exp_d = exp_adv;
          if (match) begin
            good_d = good_inc;
            if (good_inc >= GW'(LOCK_CNT)) begin
              state_d = LOCK;
              bad_d   = '0;
            end
          end else begin
            state_d = HUNT;
            good_d  = '0;
          end
        end
        LOCK: begin
          // Free-running exp: one corrupted word costs exactly one error.
          if (is_run) exp_d = exp_adv;
          if (match) begin
            bad_d = '0;
          end else begin
            err_hit = 1'b1;
            bad_d   = bad_inc;
            if (bad_inc >= UW'(UNLOCK_ERR)) begin
              state_d = HUNT;
              good_d  = '0;
              bad_d   = '0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          good_d  = '0;
          bad_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pat_d      = i_test_patten;
    word_err_d = err_hit;
    word_cnt_d = word_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    bit_sum    = SW'(bit_cnt_q) + SW'(pop);
    if (i_clr_cnt) begin
      word_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (err_hit) begin
      if (word_cnt_q != CNT_MAX) word_cnt_d = word_cnt_q + CNT_W'(1);
      bit_cnt_d = (bit_sum > SW'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      exp_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      pat_q      <= '0;
      word_err_q <= 1'b0;
      word_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      pat_q      <= pat_d;
      word_err_q <= word_err_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign o_locked       = (state_q == LOCK);
  assign o_word_err     = word_err_q;
  assign o_word_err_cnt = word_cnt_q;
  assign o_bit_err_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_bits_check.sv
// Directed bench for bits_check: lock acquisition in every pattern mode,
// error injection, counter wrap, saturation, clear priority and async reset.
module tb_bits_check;
  import bits_test_pkg::*;

  localparam int DW    = 6;
  localparam int BW    = DW * 8;
  localparam int CNT_W = 12;

  localparam logic [BW-1:0] W_CONST = {DW{8'hbc}};
  localparam logic [BW-1:0] W_BAD   = ~W_CONST;
  localparam logic [BW-1:0] W_AA    = {DW{8'haa}};
  localparam logic [BW-1:0] W_55    = {DW{8'h55}};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        i_test_patten = PAT_CNT;
  logic              i_data_vld = 1'b0;
  logic [BW-1:0]     i_test_data = '0;
  logic              i_clr_cnt = 1'b0;
  logic              o_locked, o_word_err;
  logic [CNT_W-1:0]  o_word_err_cnt, o_bit_err_cnt;

  int total = 0;
  int bad   = 0;

  bits_check #(
    .DW(DW), .CONSTANT(8'hbc), .HOT_CODE(8'haa),
    .LOCK_CNT(8), .UNLOCK_ERR(4), .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_test_patten  (i_test_patten),
    .i_data_vld     (i_data_vld),
    .i_test_data    (i_test_data),
    .i_clr_cnt      (i_clr_cnt),
    .o_locked       (o_locked),
    .o_word_err     (o_word_err),
    .o_word_err_cnt (o_word_err_cnt),
    .o_bit_err_cnt  (o_bit_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; return just after the rising edge.
  task automatic send(input logic v, input logic [BW-1:0] d, input logic clr);
    @(negedge clk);
    i_data_vld  = v;
    i_test_data = d;
    i_clr_cnt   = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [BW-1:0] seed;
    logic [BW-1:0] w;
    int nerr;
    int run;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", o_locked, 0);
    chk("rst_err", o_word_err, 0);
    chk("rst_wcnt", o_word_err_cnt, 0);
    chk("rst_bcnt", o_bit_err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter mode: lock after 8 words, then wrap through all-ones with vld gaps
    seed = 48'hffff_ffff_fff0;
    for (int i = 0; i < 8; i++) begin
      w = seed + BW'(i);
      send(1'b1, w, 1'b0);
      if (i == 6) chk("cnt_lock_early", o_locked, 0);
      if (i == 7) chk("cnt_lock", o_locked, 1);
    end
    for (int i = 8; i < 20; i++) begin
      w = seed + BW'(i);
      send(1'b1, w, 1'b0);
      chk("cnt_wrap_err", o_word_err, 0);
      repeat (3) send(1'b0, 48'hdead_beef_0000, 1'b0);
    end
    chk("cnt_wrap_locked", o_locked, 1);
    chk("cnt_wrap_wcnt", o_word_err_cnt, 0);
    for (int i = 20; i < 220; i++) begin
      w = seed + BW'(i);
      send(1'b1, w, 1'b0);
    end
    chk("cnt_run_locked", o_locked, 1);
    chk("cnt_run_wcnt", o_word_err_cnt, 0);
    chk("cnt_run_bcnt", o_bit_err_cnt, 0);

    // Switch 01 -> 11 while locked, then relock on all-ones
    i_test_patten = PAT_FF;
    send(1'b0, '0, 1'b0);
    chk("sw_ff_unlock", o_locked, 0);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, '1, 1'b0);
      if (i == 6) chk("ff_lock_early", o_locked, 0);
      if (i == 7) chk("ff_lock", o_locked, 1);
    end
    chk("ff_wcnt", o_word_err_cnt, 0);
    chk("ff_bcnt", o_bit_err_cnt, 0);

    // Constant mode: one bit flipped in one word
    i_test_patten = PAT_CONST;
    send(1'b0, '0, 1'b0);
    chk("sw_const_unlock", o_locked, 0);
    for (int i = 0; i < 8; i++) send(1'b1, W_CONST, 1'b0);
    chk("const_lock", o_locked, 1);
    send(1'b1, W_CONST ^ 48'h1, 1'b0);
    chk("const_err_pulse", o_word_err, 1);
    chk("const_wcnt", o_word_err_cnt, 1);
    chk("const_bcnt", o_bit_err_cnt, 1);
    chk("const_keep_lock", o_locked, 1);
    send(1'b1, W_CONST, 1'b0);
    chk("const_err_drop", o_word_err, 0);
    chk("const_wcnt_hold", o_word_err_cnt, 1);

    // Hot mode: counters survive the switch, then clear; illegal word must not seed
    i_test_patten = PAT_HOT;
    send(1'b0, '0, 1'b0);
    chk("sw_hot_unlock", o_locked, 0);
    chk("sw_hot_wcnt_kept", o_word_err_cnt, 1);
    chk("sw_hot_bcnt_kept", o_bit_err_cnt, 1);
    send(1'b0, '0, 1'b1);
    chk("clr_wcnt", o_word_err_cnt, 0);
    chk("clr_bcnt", o_bit_err_cnt, 0);
    send(1'b1, 48'h0000_0000_0123, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, (i % 2 == 0) ? W_AA : W_55, 1'b0);
      if (i == 6) chk("hot_lock_early", o_locked, 0);
      if (i == 7) chk("hot_lock", o_locked, 1);
    end
    for (int i = 0; i < 4; i++) begin
      send(1'b1, '0, 1'b0);
      chk("hot_zero_err", o_word_err, 1);
      if (i == 2) chk("hot_lock_3bad", o_locked, 1);
      if (i == 3) chk("hot_unlock_4bad", o_locked, 0);
    end
    chk("hot_wcnt", o_word_err_cnt, 4);
    chk("hot_bcnt", o_bit_err_cnt, 96);

    // Saturation: 3 bad + 1 good keeps lock while errors accumulate
    i_test_patten = PAT_CONST;
    send(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) send(1'b1, W_CONST, 1'b0);
    chk("sat_lock", o_locked, 1);
    nerr = 0;
    run  = 0;
    repeat (4096) begin
      if (run == 3) begin
        send(1'b1, W_CONST, 1'b0);
        run = 0;
      end
      send(1'b1, W_BAD, 1'b0);
      run++;
      nerr++;
      if (nerr == 85)   chk("bcnt_85", o_bit_err_cnt, 4080);
      if (nerr == 86)   chk("bcnt_sat", o_bit_err_cnt, 12'hfff);
      if (nerr == 4094) chk("wcnt_4094", o_word_err_cnt, 12'hffe);
      if (nerr == 4095) chk("wcnt_sat", o_word_err_cnt, 12'hfff);
    end
    chk("wcnt_sat_hold", o_word_err_cnt, 12'hfff);
    chk("bcnt_sat_hold", o_bit_err_cnt, 12'hfff);
    chk("sat_locked", o_locked, 1);
    if (run == 3) send(1'b1, W_CONST, 1'b0);
    send(1'b1, W_BAD, 1'b1);
    chk("clr_prio_wcnt", o_word_err_cnt, 0);
    chk("clr_prio_bcnt", o_bit_err_cnt, 0);
    send(1'b1, W_CONST, 1'b0);
    send(1'b1, W_CONST ^ 48'h3, 1'b0);
    chk("post_clr_wcnt", o_word_err_cnt, 1);
    chk("post_clr_bcnt", o_bit_err_cnt, 2);
    chk("post_clr_locked", o_locked, 1);

    // Async reset mid-operation
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_locked", o_locked, 0);
    chk("arst_err", o_word_err, 0);
    chk("arst_wcnt", o_word_err_cnt, 0);
    chk("arst_bcnt", o_bit_err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, W_CONST, 1'b0);
    chk("arst_relock_start", o_locked, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
